stream_packet_framer: RTL and testbench



---
 rtl/stream_packet_framer.sv | 89 ++++++++
 tb/tb_stream_packet_framer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_framer.sv
// Packet framer: groups a valid/ready word stream into packets of effLen words,
// prepends an 0xA5 header (magic, sequence, length) and flags the last payload word.
module stream_packet_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int SEQ_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           pktLen,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataInValid,
  output logic                  dataInReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutValid,
  input  logic                  dataOutReady,
  output logic                  dataOutLast,
  output logic [SEQ_WIDTH-1:0]  seqNum
);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t                  state, state_next;
  logic [15:0]             remaining;
  logic [15:0]             eff_len;
  logic [DATA_WIDTH-1:0]   header;
  logic                    slot_free;
  logic                    start;
  logic                    in_hs;
  logic                    last_hs;

  // The output register can take a new word when empty or being emptied this cycle.
  assign slot_free   = !dataOutValid || dataOutReady;
  assign dataInReady = !reset && (state == PAYLOAD) && slot_free;
  assign start       = (state == IDLE) && enable && dataInValid && slot_free;
  assign in_hs       = dataInValid && dataInReady;
  assign last_hs     = in_hs && (remaining == 16'd1);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    eff_len       = pktLen;
    header        = '0;
    if (pktLen == 16'd0 || pktLen > MAX_LEN_W) eff_len = MAX_LEN_W;
    header[31:0]  = {8'hA5, 8'(seqNum), eff_len};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = PAYLOAD;
      PAYLOAD: if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut      <= '0;
      dataOutValid <= 1'b0;
      dataOutLast  <= 1'b0;
      seqNum       <= '0;
      remaining    <= '0;
    end else if (start) begin
      dataOut      <= header;
      dataOutValid <= 1'b1;
      dataOutLast  <= 1'b0;
      remaining    <= eff_len;
    end else if (in_hs) begin
      dataOut      <= dataIn;
      dataOutValid <= 1'b1;
      dataOutLast  <= last_hs;
      remaining    <= remaining - 16'd1;
      if (last_hs) seqNum <= seqNum + SEQ_WIDTH'(1);
    end else if (dataOutReady) begin
      dataOutValid <= 1'b0;
      dataOutLast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packet_framer.sv
// Scoreboard bench for stream_packet_framer: packets are planned at a high level,
// expected beats queued at issue time, and a monitor compares every accepted output beat.
module tb_stream_packet_framer;

  localparam int DW = 32;
  localparam int ML = 16;
  localparam int SW = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [15:0]   pktLen;
  logic [DW-1:0] dataIn;
  logic          dataInValid;
  logic          dataInReady;
  logic [DW-1:0] dataOut;
  logic          dataOutValid;
  logic          dataOutReady;
  logic          dataOutLast;
  logic [SW-1:0] seqNum;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    seq_model = 0;
  int    ready_mode = 0;
  int    cyc = 0;
  int    pidx = 0;
  int    pat[4] = '{1, 0, 0, 1};
  bit    prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic  prev_last;

  stream_packet_framer #(.DATA_WIDTH(DW), .MAX_LEN(ML), .SEQ_WIDTH(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pktLen       (pktLen),
    .dataIn       (dataIn),
    .dataInValid  (dataInValid),
    .dataInReady  (dataInReady),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .dataOutReady (dataOutReady),
    .dataOutLast  (dataOutLast),
    .seqNum       (seqNum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Downstream ready: always on, random, or the 1,0,0,1 pattern.
  initial begin
    dataOutReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dataOutReady = 1'b1;
        1:       dataOutReady = ($urandom_range(0, 2) != 0);
        default: begin
          dataOutReady = (pat[pidx % 4] != 0);
          pidx++;
        end
      endcase
    end
  end

  // Monitor: compares accepted beats against the scoreboard and checks stall stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", dataOutValid, 1);
          check("hold_data", dataOut, prev_data);
          check("hold_last", dataOutLast, prev_last);
        end
        prev_stall = dataOutValid && !dataOutReady;
        if (prev_stall) begin
          prev_data = dataOut;
          prev_last = dataOutLast;
          check("stall_in_ready", dataInReady, 0);
        end
        if (dataOutValid && dataOutReady) begin
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got 0x%0h last=%0d with nothing expected", dataOut, dataOutLast);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", dataOut, e.data);
            check("beat_last", dataOutLast, e.last);
          end
        end
      end
    end
  end

  function automatic int eff_of(input int len);
    return (len == 0 || len > ML) ? ML : len;
  endfunction

  function automatic logic [31:0] header_of(input int seq, input int eff);
    return 32'hA500_0000 + 32'(seq << 16) + 32'(eff);
  endfunction

  task automatic wait_hs();
    bit hs;
    int guard;
    hs = 0;
    guard = 0;
    while (!hs && guard < 500) begin
      @(negedge clk);
      hs = dataInReady;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!hs) begin
      n_checks++;
      $display("FAIL in_handshake_timeout: dataInReady never rose within 500 cycles");
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Plans one packet (header + eff words) into the scoreboard, then feeds its words.
  task automatic send_packet(input int len, input int max_gap, input bit noisy, input logic [31:0] base);
    int          eff;
    int          gap;
    logic [31:0] w[$];
    logic [31:0] wd;
    beat_t       b;
    eff = eff_of(len);
    b.data = header_of(seq_model, eff);
    b.last = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < eff; i++) begin
      wd = (base != 0) ? 32'(base * (i + 1)) : $urandom;
      w.push_back(wd);
      b.data = wd;
      b.last = (i == eff - 1);
      exp_q.push_back(b);
    end
    seq_model = (seq_model + 1) % (1 << SW);
    pktLen = 16'(len);
    enable = 1'b1;
    for (int i = 0; i < eff; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (gap > 0) begin
        dataInValid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      dataIn = w[i];
      dataInValid = 1'b1;
      wait_hs();
      if (noisy) begin
        enable = 1'($urandom);
        pktLen = 16'($urandom);
      end
    end
    dataInValid = 1'b0;
  endtask

  initial begin
    beat_t b;
    logic [31:0] w0;
    int len;
    reset = 1'b1;
    enable = 1'b0;
    pktLen = '0;
    dataIn = '0;
    dataInValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", dataOutValid, 0);
    check("rst_last", dataOutLast, 0);
    check("rst_data", dataOut, 0);
    check("rst_seq", seqNum, 0);
    check("rst_in_ready", dataInReady, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single 3-word packet with ready held high: four consecutive beats.
    beat_cyc.delete();
    send_packet(3, 0, 0, 32'h11);
    wait_drain();
    check("t1_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("t1_span", 64'(beat_cyc[3] - beat_cyc[0]), 3);
    check("t1_seq", seqNum, 64'(seq_model));

    // Two back-to-back 2-word packets: six beats, no bubble.
    beat_cyc.delete();
    send_packet(2, 0, 0, 0);
    send_packet(2, 0, 0, 0);
    wait_drain();
    check("t2_beats", beat_cyc.size(), 6);
    if (beat_cyc.size() == 6) check("t2_span", 64'(beat_cyc[5] - beat_cyc[0]), 5);
    check("t2_seq", seqNum, 64'(seq_model));

    // Length clamping: 0 and over-max both become MAX_LEN.
    ready_mode = 1;
    send_packet(0, 2, 1, 0);
    send_packet(40, 2, 1, 0);
    wait_drain();
    check("t3_seq", seqNum, 64'(seq_model));

    // Backpressure pattern 1,0,0,1.
    ready_mode = 2;
    send_packet(4, 0, 0, 0);
    send_packet(3, 1, 0, 0);
    wait_drain();

    // Sequence wrap with 1-word packets.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) send_packet(1, 1, 0, 0);
    wait_drain();
    check("t5_seq", seqNum, 64'(seq_model));

    // enable low in IDLE blocks a start even with input available.
    enable = 1'b0;
    dataInValid = 1'b1;
    dataIn = 32'hCAFE_F00D;
    repeat (5) begin
      @(negedge clk);
      check("en_off_valid", dataOutValid, 0);
    end
    @(posedge clk);
    #1;
    dataInValid = 1'b0;
    enable = 1'b1;

    // Reset after header and one payload word of a 4-word packet.
    w0 = $urandom;
    b.data = header_of(seq_model, 4);
    b.last = 1'b0;
    exp_q.push_back(b);
    b.data = w0;
    exp_q.push_back(b);
    pktLen = 16'd4;
    dataIn = w0;
    dataInValid = 1'b1;
    wait_hs();
    dataInValid = 1'b0;
    wait_drain();
    reset = 1'b1;
    @(negedge clk);
    check("t6_in_ready_rst", dataInReady, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", dataOutValid, 0);
    check("t6_last", dataOutLast, 0);
    check("t6_seq", seqNum, 0);
    seq_model = 0;
    @(posedge clk);
    #1;
    send_packet(2, 0, 0, 0);
    wait_drain();

    // Randomised traffic.
    for (int p = 0; p < 30; p++) begin
      ready_mode = $urandom_range(0, 2);
      len = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 20);
      send_packet(len, 3, 1, 0);
    end
    wait_drain();
    check("rand_seq", seqNum, 64'(seq_model));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
